// File: rtl/fir_result_uart_tx.sv
// Scales and saturates fir_filter_128 outputs to 16 bits, queues them, and sends
// each one as a 3-byte UART frame (SYNC_BYTE, high byte, low byte), 8N1, LSB first.
module fir_result_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          SHIFT        = 15,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [31:0]            y_in,
  input  logic                          y_valid,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          saturated
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Returns {clipped, value}: arithmetic shift then clamp to signed 16 bits.
  function automatic logic [16:0] scale_sat(input logic signed [31:0] v);
    logic signed [31:0] s;
    s = v >>> SHIFT;
    if (s > 32'sd32767)
      return {1'b1, 16'h7FFF};
    else if (s < -32'sd32768)
      return {1'b1, 16'h8000};
    else
      return {1'b0, s[15:0]};
  endfunction

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   level;
  logic             full, pop, push;
  logic [16:0]      scaled;

  logic [1:0]       state;
  logic [1:0]       k;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] baud;
  logic [15:0]      sample;
  logic [7:0]       cur_byte;
  logic             baud_done;

  assign scaled    = scale_sat(y_in);
  assign full      = (level == FULL_LVL);
  assign pop       = (state == IDLE) && (level != '0);
  // A full FIFO still accepts a sample when the same edge frees a slot.
  assign push      = y_valid && (!full || pop);
  assign baud_done = (baud == CNT_MAX);

  always_comb begin
    cur_byte = sample[7:0];
    case (k)
      2'd0:    cur_byte = SYNC_BYTE;
      2'd1:    cur_byte = sample[15:8];
      default: cur_byte = sample[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= scaled[15:0];
    if (pop)  sample    <= mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      saturated <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && scaled[16])          saturated <= 1'b1;
      if (y_valid && full && !pop)     overflow  <= 1'b1;
    end
  end

  // tx is registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= 2'd0;
      bit_idx <= 3'd0;
      baud    <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (level != '0) begin
            k     <= 2'd0;
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          tx <= cur_byte[bit_idx];
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_done) begin
            baud <= '0;
            if (k == 2'd2) begin
              state <= IDLE;
            end else begin
              k     <= k + 1'b1;
              state <= START;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE) || (level != '0);
  assign fifo_level = level;

endmodule
